// File: rtl/cm_sketch_update.sv
// Count-min sketch front end: hashes each access address into NUM_ROW rows of
// saturating counters and reports the address with its min-of-rows estimate.
module cm_sketch_update #(
    parameter int ADDR_SIZE      = 22,
    parameter int CNT_SIZE       = 32,
    parameter int NUM_ROW        = 4,
    parameter int COL_INDEX_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [ADDR_SIZE-1:0] in_addr,
    output logic                 in_ready,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic                 out_valid,
    output logic [ADDR_SIZE-1:0] out_addr,
    output logic [CNT_SIZE-1:0]  out_cnt
);

    localparam int NUM_COL   = 1 << COL_INDEX_SIZE;
    localparam int NUM_CHUNK = (ADDR_SIZE + COL_INDEX_SIZE - 1) / COL_INDEX_SIZE;
    localparam int PAD_SIZE  = NUM_CHUNK * COL_INDEX_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        HASH,
        UPDATE,
        EMIT,
        CLEAR
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_SIZE-1:0]      addr_q;
    logic [COL_INDEX_SIZE-1:0] idx_q     [NUM_ROW];
    logic [COL_INDEX_SIZE-1:0] hash_idx  [NUM_ROW];
    logic [CNT_SIZE-1:0]       cnt_mem   [NUM_ROW][NUM_COL];
    logic [CNT_SIZE-1:0]       old_cnt   [NUM_ROW];
    logic [CNT_SIZE-1:0]       new_cnt   [NUM_ROW];
    logic [CNT_SIZE-1:0]       min_new;
    logic [COL_INDEX_SIZE-1:0] clear_ptr;
    logic                      clear_pending;
    logic                      handshake;
    logic                      clear_start;

    // Row hash: rotate left by 3*row, zero-pad to whole chunks, XOR-fold chunks.
    function automatic logic [COL_INDEX_SIZE-1:0] row_hash(
        input logic [ADDR_SIZE-1:0] addr,
        input int                   row
    );
        logic [2*ADDR_SIZE-1:0]    dbl;
        logic [PAD_SIZE-1:0]       ext;
        logic [COL_INDEX_SIZE-1:0] idx;
        int                        shift;
        shift = (3 * row) % ADDR_SIZE;
        dbl   = {addr, addr} << shift;
        ext   = PAD_SIZE'(dbl[2*ADDR_SIZE-1 -: ADDR_SIZE]);
        idx   = '0;
        for (int c = 0; c < NUM_CHUNK; c++) begin
            idx = idx ^ ext[c*COL_INDEX_SIZE +: COL_INDEX_SIZE];
        end
        return idx;
    endfunction

    always_comb begin
        for (int r = 0; r < NUM_ROW; r++) begin
            hash_idx[r] = row_hash(addr_q, r);
        end
    end

    // Saturating increment per row and the minimum across rows.
    always_comb begin
        min_new = '1;
        for (int r = 0; r < NUM_ROW; r++) begin
            old_cnt[r] = cnt_mem[r][idx_q[r]];
            new_cnt[r] = (old_cnt[r] == '1) ? old_cnt[r] : old_cnt[r] + CNT_SIZE'(1);
            if (new_cnt[r] < min_new) begin
                min_new = new_cnt[r];
            end
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        clear_busy  = 1'b0;
        out_valid   = 1'b0;
        handshake   = 1'b0;
        clear_start = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !clear_req && !clear_pending;
                if (in_valid && in_ready) begin
                    handshake  = 1'b1;
                    state_next = HASH;
                end else if (clear_req || clear_pending) begin
                    clear_start = 1'b1;
                    state_next  = CLEAR;
                end
            end
            HASH:   state_next = UPDATE;
            UPDATE: state_next = EMIT;
            EMIT: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            CLEAR: begin
                clear_busy = 1'b1;
                if (clear_ptr == COL_INDEX_SIZE'(NUM_COL - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            out_addr      <= '0;
            out_cnt       <= '0;
            clear_ptr     <= '0;
            clear_pending <= 1'b0;
            for (int r = 0; r < NUM_ROW; r++) begin
                idx_q[r] <= '0;
            end
        end else begin
            state <= state_next;
            if (handshake) begin
                addr_q <= in_addr;
            end
            if (state == HASH) begin
                idx_q <= hash_idx;
            end
            if (state == UPDATE) begin
                out_cnt  <= min_new;
                out_addr <= addr_q;
            end
            if (clear_start) begin
                clear_ptr <= '0;
            end else if (state == CLEAR) begin
                clear_ptr <= clear_ptr + COL_INDEX_SIZE'(1);
            end
            // A clear arriving mid-access is remembered; requests during a sweep are dropped.
            if (clear_start) begin
                clear_pending <= 1'b0;
            end else if (clear_req && (state == HASH || state == UPDATE || state == EMIT)) begin
                clear_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                for (int c = 0; c < NUM_COL; c++) begin
                    cnt_mem[r][c] <= '0;
                end
            end
        end else if (state == UPDATE) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                cnt_mem[r][idx_q[r]] <= new_cnt[r];
            end
        end else if (state == CLEAR) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                cnt_mem[r][clear_ptr] <= '0;
            end
        end
    end

endmodule

// File: doc/cm_sketch_update.md
Name: cm_sketch_update

Overview:
- Count-min sketch front end for the hot-address tracker.
- Takes a stream of access addresses and hashes each one into NUM_ROW rows of 2^COL_INDEX_SIZE saturating counters.
- Increments the selected counter in every row, then emits the address with its min-of-rows estimated count.
- Output feeds the sorted top-K CAM stage directly, with the spacing that stage requires.

Parameters:
- ADDR_SIZE, 22, access address width; matches CAM addr width.
- CNT_SIZE, 32, counter width; matches CAM count width.
- NUM_ROW, 4, number of sketch rows / hash functions (1..8).
- COL_INDEX_SIZE, 6, log2 of counters per row (64 columns).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  access address valid
- in_addr  in  ADDR_SIZE  access address
- in_ready  out  1  block can accept an address this cycle
- clear_req  in  1  request to zero all counters (epoch boundary)
- clear_busy  out  1  counter sweep in progress
- out_valid  out  1  one-cycle pulse; out_addr/out_cnt valid
- out_addr  out  ADDR_SIZE  address being reported
- out_cnt  out  CNT_SIZE  min-of-rows count after this access's increment

Behaviour:
- Reset: all counters 0, state IDLE. Outputs in_ready=1, clear_busy=0, out_valid=0, out_addr=0, out_cnt=0; clear_pending=0.
- Hash for row r:
  - a_r = addr rotated left by (3*r) mod ADDR_SIZE within ADDR_SIZE bits.
  - Zero-extend a_r to a multiple of COL_INDEX_SIZE.
  - idx_r = XOR of all consecutive COL_INDEX_SIZE-bit chunks of a_r.
- in_ready = (state==IDLE) && !clear_req && !clear_pending. Handshake = in_valid && in_ready; in_addr is captured on that edge.
- States:
  - IDLE:
    - handshake -> HASH.
    - else if clear_req or clear_pending -> CLEAR (col ptr=0).
  - HASH: register idx_r for all rows -> UPDATE.
  - UPDATE:
    - Per row, new_r = old_r + 1, saturating at all-ones (no wrap); write new_r back.
    - Register min over rows of new_r -> EMIT.
  - EMIT: out_valid=1 for exactly this cycle, out_addr = captured address, out_cnt = registered min -> IDLE.
  - CLEAR:
    - Each cycle, zero column ptr in all rows; ptr++.
    - Leave when ptr == 2^COL_INDEX_SIZE-1 is zeroed -> IDLE.
    - clear_busy=1 throughout CLEAR.
- Latency: handshake edge to out_valid = 3 cycles. Throughput: at most 1 address per 4 cycles. out_valid pulses are therefore separated by >=3 low cycles, which satisfies the downstream one-cycle-lookup acceptance rule.
- out_addr/out_cnt hold their last values between pulses.
- clear_req while not IDLE sets clear_pending. It is serviced on the next IDLE, before any new handshake. clear_pending clears on entry to CLEAR.
- clear_req asserted in the same cycle as in_valid while IDLE: clear wins, no handshake (in_ready=0).
- clear_req during CLEAR is ignored (no restart).
- Hash collision between rows is impossible (separate arrays). Identical idx in different rows is independent.
- Counters saturate at 2^CNT_SIZE-1; out_cnt saturates accordingly.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight access is dropped with no out_valid; a partial clear is abandoned (all counters zeroed by reset anyway).
- in_valid while in_ready=0 is not captured. Upstream must hold it.

Test Plan:
- Single access: after reset, in_addr=0x00ABC for 1 cycle -> out_valid exactly 3 cycles later, out_addr=0x00ABC, out_cnt=1. in_ready low for 3 cycles.
- Repeat: 5 back-to-back accesses of 0x12345 held on in_valid -> 5 pulses, 4 cycles apart, out_cnt=1,2,3,4,5.
- Collision: two addresses sharing idx_0 but differing in other rows, A x3 then B x1 -> B reports out_cnt=1 (min), not 4.
- Clear: after 10 accesses of 0x3F, assert clear_req in IDLE -> clear_busy high 64 cycles, in_ready low. Next access of 0x3F gives out_cnt=1.
- Clear race: clear_req in HASH cycle -> current access still emits. CLEAR then starts right after EMIT; an in_valid held meanwhile is accepted only after clear_busy falls.
- Saturation and reset: CNT_SIZE=4, 20 accesses of one address -> out_cnt stops at 15. rst_n pulsed mid-UPDATE -> no out_valid, next access gives out_cnt=1.
